// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine water-inlet arbiter.
// Latency: none (types, constants and an elaboration-time helper only).
// Backpressure: not applicable.
//
// Contents: arbiter state enum, default parameter values, width helper.
package wm_pkg;

   // Arbiter states: waiting for a requester, inlet granted, pressure settling.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_SETTLE = 2'd2
   } wm_state_e;

   localparam int WM_N_DEF       = 4;
   localparam int WM_TIMEOUT_DEF = 1000;
   localparam int WM_SETTLE_DEF  = 4;

   // Bits needed to index/count 'value' distinct states; never less than 1
   // so a degenerate parameter still yields a legal vector.
   function automatic int wm_width(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/wm_fill_arbiter_if.sv
// Bundle of the per-machine fill handshake between washer controllers and the inlet arbiter.
// Latency: none (wiring only).
// Backpressure: none; requests are levels held until the grant is no longer needed.
//
// Signals: fill_req/fault_clr (controllers -> arbiter), grant/valve_on/busy_id/fault
// (arbiter -> controllers and inlet valve). master = controller side, slave = arbiter.
interface wm_fill_arbiter_if
   import wm_pkg::*;
#(
   parameter int N = WM_N_DEF
);
   localparam int IW = wm_width(N);

   logic [N-1:0]  fill_req;
   logic [N-1:0]  fault_clr;
   logic [N-1:0]  grant;
   logic          valve_on;
   logic [IW-1:0] busy_id;
   logic [N-1:0]  fault;

   modport master (
      output fill_req, fault_clr,
      input  grant, valve_on, busy_id, fault
   );

   modport slave (
      input  fill_req, fault_clr,
      output grant, valve_on, busy_id, fault
   );

endinterface

// File: rtl/wm_rr_pick.sv
// Wrap-around first-set search: lowest request at or above ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: req[N] candidate set, ptr search start; valid = any candidate, sel = chosen index.
module wm_rr_pick
   import wm_pkg::*;
#(
   parameter int N = WM_N_DEF,
   localparam int IW = wm_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] sel
);

   // One extra bit so ptr+k can exceed N-1 before being folded back.
   localparam int SW = IW + 1;

   logic [SW-1:0] idx;

   always_comb begin
      valid = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, ptr} + SW'(k);
         if (idx >= SW'(N)) begin
            idx = idx - SW'(N);
         end
         if (!valid && req[idx[IW-1:0]]) begin
            valid = 1'b1;
            sel   = idx[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/wm_fill_arbiter.sv
// Round-robin owner of the building water inlet, one washer at a time, with settle gap and watchdog.
// Latency: request seen in IDLE -> grant on the next edge; request drop -> grant low on the next edge.
// Backpressure: no preemption; other requests wait through GRANT and SETTLE, faulted machines wait for fault_clr.
//
// Ports: clk, reset (sync, active high), bus (slave modport: fill_req, fault_clr in;
// grant, valve_on, busy_id, fault out -- all outputs registered).
module wm_fill_arbiter
   import wm_pkg::*;
#(
   parameter int N       = WM_N_DEF,
   parameter int TIMEOUT = WM_TIMEOUT_DEF,
   parameter int SETTLE  = WM_SETTLE_DEF
) (
   input logic              clk,
   input logic              reset,
   wm_fill_arbiter_if.slave bus
);

   localparam int IW = wm_width(N);
   // Counter must reach both TIMEOUT-1 and SETTLE-1; sized on the larger of the two.
   localparam int CW = wm_width(((TIMEOUT > SETTLE) ? TIMEOUT : SETTLE) + 1);

   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   wm_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  grant_q, grant_d;
   logic          valve_q, valve_d;
   logic [IW-1:0] busy_q, busy_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  fault_q, fault_d;
   logic [N-1:0]  fault_set;

   logic [N-1:0]  eligible;
   logic          pick_valid;
   logic [IW-1:0] pick_sel;
   logic [IW-1:0] busy_next;
   logic [CW-1:0] cnt_inc;

   assign eligible = bus.fill_req & ~fault_q;

   wm_rr_pick #(
      .N (N)
   ) u_pick (
      .req   (eligible),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .sel   (pick_sel)
   );

   // Round-robin successor of the current owner.
   assign busy_next = (busy_q == IW'(N - 1)) ? '0 : busy_q + IW'(1);

   // Saturating increment: the counter must never wrap back into range.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      ptr_d     = ptr_q;
      fault_set = '0;

      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            if (pick_valid) begin
               grant_d = N'(1) << pick_sel;
               busy_d  = pick_sel;
               cnt_d   = '0;
               state_d = ST_GRANT;
            end
         end

         ST_GRANT: begin
            cnt_d = cnt_inc;
            if (!bus.fill_req[busy_q]) begin
               grant_d = '0;
               ptr_d   = busy_next;
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end else if (cnt_q == TO_LAST) begin
               // Held for TIMEOUT cycles with the request still up: lock the machine out.
               fault_set = N'(1) << busy_q;
               grant_d   = '0;
               ptr_d     = busy_next;
               cnt_d     = '0;
               state_d   = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            grant_d = '0;
            if (cnt_q == SET_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         default: begin
            grant_d = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      // Set beats clear when both hit the same bit in one cycle.
      fault_d = (fault_q & ~bus.fault_clr) | fault_set;

      // Valve follows the grant being registered, gated by the live request.
      valve_d = |(grant_d & bus.fill_req);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         valve_q <= 1'b0;
         busy_q  <= '0;
         ptr_q   <= '0;
         fault_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         valve_q <= valve_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
         fault_q <= fault_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.valve_on = valve_q;
   assign bus.busy_id  = busy_q;
   assign bus.fault    = fault_q;

endmodule

// File: tb/tb_wm_fill_arbiter.sv
// Scoreboard bench for wm_fill_arbiter (N=4, TIMEOUT=20, SETTLE=4).
// Stimulus pushes the expected output snapshot for every change it provokes;
// the monitor pops one entry per observed change of {grant, valve_on, busy_id, fault}.
module tb_wm_fill_arbiter;

   localparam int N       = 4;
   localparam int TIMEOUT = 20;
   localparam int SETTLE  = 4;

   logic clk;
   logic reset;

   wm_fill_arbiter_if #(.N(N)) bus ();

   wm_fill_arbiter #(
      .N       (N),
      .TIMEOUT (TIMEOUT),
      .SETTLE  (SETTLE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] grant;
      logic       valve;
      logic [1:0] busy;
      logic [3:0] fault;
      int         dur;   // cycles since previous change; 0 = not checked
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic push_exp(input logic [3:0] g, input logic v, input logic [1:0] b,
                           input logic [3:0] f, input int d);
      exp_t e;
      e.grant = g;
      e.valve = v;
      e.busy  = b;
      e.fault = f;
      e.dur   = d;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   task automatic check_event(input int n, input int dur);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL event%0d unexpected: got grant=%b valve=%b busy=%0d fault=%b dur=%0d, expected no change",
                  n, bus.grant, bus.valve_on, bus.busy_id, bus.fault, dur);
      end else begin
         e = exp_q.pop_front();
         if (bus.grant !== e.grant || bus.valve_on !== e.valve || bus.busy_id !== e.busy ||
             bus.fault !== e.fault || (e.dur != 0 && dur != e.dur)) begin
            failures++;
            $display("FAIL event%0d: got grant=%b valve=%b busy=%0d fault=%b dur=%0d, want grant=%b valve=%b busy=%0d fault=%b dur=%0d",
                     n, bus.grant, bus.valve_on, bus.busy_id, bus.fault, dur,
                     e.grant, e.valve, e.busy, e.fault, e.dur);
         end
      end
   endtask

   initial begin
      int cyc;
      int last_cyc;
      int n_ev;
      int guard;
      logic [10:0] last_snap;
      logic [10:0] cur_snap;
      cyc = 0;
      last_cyc = 0;
      n_ev = 0;
      guard = 0;
      @(posedge clk); #1;
      while (reset !== 1'b0 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      // First sample after reset release: the reset state itself.
      check_event(n_ev, 0);
      n_ev++;
      last_snap = {bus.grant, bus.valve_on, bus.busy_id, bus.fault};
      forever begin
         @(posedge clk); #1;
         cyc++;
         cur_snap = {bus.grant, bus.valve_on, bus.busy_id, bus.fault};
         if (cur_snap !== last_snap) begin
            check_event(n_ev, cyc - last_cyc);
            n_ev++;
            last_snap = cur_snap;
            last_cyc  = cyc;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_grant(input logic [3:0] mask, input int budget, input string name);
      int n;
      n = 0;
      while (bus.grant !== mask && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (bus.grant !== mask) begin
         checks++;
         failures++;
         $display("FAIL %s timeout: grant=%b, waited for %b", name, bus.grant, mask);
      end
   endtask

   // Wait for machine idx to own the inlet, keep it h cycles, drop the
   // request, then once the grant is gone apply the next request pattern.
   task automatic hold_release(input int idx, input int h, input logic [3:0] flt,
                               input logic [3:0] after);
      logic [3:0] m;
      m = 4'b0001 << idx;
      wait_grant(m, 60, "grant_wait");
      repeat (h - 1) @(negedge clk);
      push_exp(4'b0000, 1'b0, 2'(idx), flt, h);
      bus.fill_req[idx] = 1'b0;
      wait_grant(4'b0000, 60, "release_wait");
      bus.fill_req = after;
   endtask

   initial begin
      int seq[5];
      seq = '{0, 1, 2, 3, 0};
      reset         = 1'b1;
      bus.fill_req  = '0;
      bus.fault_clr = '0;

      // Reset state.
      push_exp(4'b0000, 1'b0, 2'd0, 4'b0000, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Single requester 0, released after 6 cycles.
      repeat (2) @(negedge clk);
      push_exp(4'b0001, 1'b1, 2'd0, 4'b0000, 0);
      bus.fill_req = 4'b0001;
      hold_release(0, 6, 4'b0000, 4'b0010);

      // Machine 1; during its settle, 1 re-requests and 3 arrives with ptr=2 -> 3 wins.
      push_exp(4'b0010, 1'b1, 2'd1, 4'b0000, SETTLE + 1);
      hold_release(1, 6, 4'b0000, 4'b1010);
      push_exp(4'b1000, 1'b1, 2'd3, 4'b0000, SETTLE + 1);
      hold_release(3, 6, 4'b0000, 4'b0100);

      // Machine 2 never releases: watchdog after TIMEOUT cycles.
      push_exp(4'b0100, 1'b1, 2'd2, 4'b0000, SETTLE + 1);
      wait_grant(4'b0100, 60, "wd2_grant");
      push_exp(4'b0000, 1'b0, 2'd2, 4'b0100, TIMEOUT);
      wait_grant(4'b0000, 40, "wd2_trip");
      // Still requesting but locked out: no change expected here.
      repeat (30) @(negedge clk);
      // Clearing the fault lets it back in one arbitration cycle later.
      push_exp(4'b0000, 1'b0, 2'd2, 4'b0000, 0);
      push_exp(4'b0100, 1'b1, 2'd2, 4'b0000, 1);
      bus.fault_clr = 4'b0100;
      @(negedge clk);
      bus.fault_clr = 4'b0000;
      hold_release(2, 6, 4'b0000, 4'b0010);

      // Machine 1 trips the watchdog with fault_clr[1] on the same edge: set wins.
      push_exp(4'b0010, 1'b1, 2'd1, 4'b0000, SETTLE + 1);
      wait_grant(4'b0010, 60, "wd1_grant");
      repeat (TIMEOUT - 1) @(negedge clk);
      push_exp(4'b0000, 1'b0, 2'd1, 4'b0010, TIMEOUT);
      bus.fault_clr = 4'b0010;
      @(negedge clk);
      bus.fault_clr = 4'b0000;
      bus.fill_req  = 4'b0000;
      @(negedge clk);
      push_exp(4'b0000, 1'b0, 2'd1, 4'b0000, 0);
      bus.fault_clr = 4'b0010;
      @(negedge clk);
      bus.fault_clr = 4'b0000;
      push_exp(4'b1000, 1'b1, 2'd3, 4'b0000, 3);
      bus.fill_req  = 4'b1000;

      // Machine 3 trips too, leaving fault=1000 in place for the reset check.
      wait_grant(4'b1000, 60, "wd3_grant");
      push_exp(4'b0000, 1'b0, 2'd3, 4'b1000, TIMEOUT);
      wait_grant(4'b0000, 40, "wd3_trip");
      bus.fill_req = 4'b0001;

      // 0 then 1 (ptr becomes 1), reset mid-grant of machine 1.
      push_exp(4'b0001, 1'b1, 2'd0, 4'b1000, SETTLE + 1);
      hold_release(0, 6, 4'b1000, 4'b0010);
      push_exp(4'b0010, 1'b1, 2'd1, 4'b1000, SETTLE + 1);
      wait_grant(4'b0010, 60, "pre_reset_grant");
      repeat (2) @(negedge clk);
      push_exp(4'b0000, 1'b0, 2'd0, 4'b0000, 3);
      reset        = 1'b1;
      bus.fill_req = 4'b0011;
      @(negedge clk);
      reset        = 1'b0;
      bus.fill_req = 4'b1111;
      // ptr back to 0 so machine 0 wins immediately.
      push_exp(4'b0001, 1'b1, 2'd0, 4'b0000, 1);

      // All four requesting: rotation 0,1,2,3,0 with a settle gap each time.
      for (int i = 0; i < 5; i++) begin
         hold_release(seq[i], 10, 4'b0000, (i < 4) ? 4'b1111 : 4'b0000);
         if (i < 4) begin
            push_exp(4'b0001 << seq[i + 1], 1'b1, 2'(seq[i + 1]), 4'b0000, SETTLE + 1);
         end
      end

      repeat (10) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_expect: %0d expected changes never seen, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

endmodule
